// File: rtl/vec_pkg.sv
// vec_pkg: shared vector-unit op codes, controller states and default widths
package vec_pkg;
  localparam int VEC_ADDR_W = 8;
  localparam int VEC_LEN_W = 8;
  typedef enum logic [1:0] {
    VEC_UNIT_OP_ADD,
    VEC_UNIT_OP_SUB,
    VEC_UNIT_OP_MUL,
    VEC_UNIT_OP_MAX
  } VecUnitOp_t;
  typedef enum logic [1:0] {
    VEC_CTRL_IDLE,
    VEC_CTRL_RUN,
    VEC_CTRL_DRAIN,
    VEC_CTRL_DONE
  } VecCtrlState_t;
endpackage

// File: rtl/vec_ctrl.sv
// vec_ctrl: sequences chunked read/write for the vector unit; define VEC_CTRL_RANGE_CHECK_EN to reject commands that run past the address space
module vec_ctrl
  import vec_pkg::*;
#(
  parameter int ADDR_W = VEC_ADDR_W,
  parameter int LEN_W = VEC_LEN_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  VecUnitOp_t        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_src2,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output VecUnitOp_t        unit_op,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);
  VecCtrlState_t state, state_nx;
  VecUnitOp_t op_q;
  logic [ADDR_W-1:0] src1_q, src2_q, dst_q;
  logic [LEN_W-1:0] len_q, rd_idx, wr_idx;
  logic wr_en_q, accept, stall, bad;
  // ready is forced low while reset is held so nothing is accepted mid-reset
  assign cmd_ready = reset_n && state == VEC_CTRL_IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign stall = wr_en_q && !wr_ready;
  assign busy = state != VEC_CTRL_IDLE;
  assign done = state == VEC_CTRL_DONE;
  assign wr_en = wr_en_q;
  assign unit_op = op_q;
  assign rd_addr1 = src1_q + ADDR_W'(rd_idx);
  assign rd_addr2 = src2_q + ADDR_W'(rd_idx);
  assign wr_addr = dst_q + ADDR_W'(wr_idx);
`ifdef VEC_CTRL_RANGE_CHECK_EN
  localparam logic [32:0] SPAN = 33'(1) << ADDR_W;
  logic err_q;
  assign bad = 33'(cmd_src1) + 33'(cmd_len) > SPAN || 33'(cmd_src2) + 33'(cmd_len) > SPAN ||
               33'(cmd_dst) + 33'(cmd_len) > SPAN;
  assign err = done && err_q;
  // remember whether the accepted command was rejected so err pairs with done
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) err_q <= 1'b0;
    else if (accept) err_q <= bad;
`else
  assign bad = 1'b0;
  assign err = 1'b0;
`endif
  // state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= VEC_CTRL_IDLE;
    else state <= state_nx;
  // next state and read strobe; reads pause whenever the pending write is stalled
  always_comb begin
    state_nx = state;
    rd_en = 1'b0;
    case (state)
      VEC_CTRL_IDLE:
        state_nx = accept ? (cmd_len == '0 || bad ? VEC_CTRL_DONE : VEC_CTRL_RUN) : VEC_CTRL_IDLE;
      VEC_CTRL_RUN: begin
        rd_en = !stall;
        state_nx = rd_en && rd_idx == len_q - LEN_W'(1) ? VEC_CTRL_DRAIN : VEC_CTRL_RUN;
      end
      VEC_CTRL_DRAIN: state_nx = wr_ready ? VEC_CTRL_DONE : VEC_CTRL_DRAIN;
      default: state_nx = VEC_CTRL_IDLE;
    endcase
  end
  // command latch and read-to-write pipeline stage
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      op_q <= VEC_UNIT_OP_ADD;
      src1_q <= '0;
      src2_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      rd_idx <= '0;
      wr_idx <= '0;
      wr_en_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= cmd_op;
        src1_q <= cmd_src1;
        src2_q <= cmd_src2;
        dst_q <= cmd_dst;
        len_q <= cmd_len;
        rd_idx <= '0;
      end
      if (rd_en) begin
        rd_idx <= rd_idx + LEN_W'(1);
        wr_idx <= rd_idx;
        wr_en_q <= 1'b1;
      end else if (wr_en_q && wr_ready) wr_en_q <= 1'b0;
    end
endmodule

// File: tb/tb_vec_ctrl.sv
// tb_vec_ctrl: scoreboard bench for vec_ctrl; expected reads, writes and completions are queued per command and checked as the DUT emits them
module tb_vec_ctrl;
  import vec_pkg::*;
  typedef struct {
    int cyc;
    int a1;
    int a2;
    int op;
    int e;
  } ev_t;
  logic clock = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0, wr_ready = 1'b1;
  VecUnitOp_t cmd_op = VEC_UNIT_OP_ADD;
  logic [7:0] cmd_src1 = '0, cmd_src2 = '0, cmd_dst = '0, cmd_len = '0;
  logic cmd_ready, rd_en, wr_en, busy, done, err;
  logic [7:0] rd_addr1, rd_addr2, wr_addr;
  VecUnitOp_t unit_op;
  ev_t rdq[$], wrq[$], dnq[$];
  ev_t me;
  int n_chk = 0, n_fail = 0, cyc = 0;

  vec_ctrl dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
    .cmd_len(cmd_len), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .unit_op(unit_op), .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void prd(input int c, input int a1, input int a2);
    rdq.push_back('{c, a1, a2, 0, 0});
  endfunction

  function automatic void pwr(input int c, input int a, input int op);
    wrq.push_back('{c, a, 0, op, 0});
  endfunction

  function automatic void pdn(input int c, input int e);
    dnq.push_back('{c, 0, 0, 0, e});
  endfunction

  // monitor: cycle index is relative to the most recent accept
  always @(negedge clock) begin
    if (cmd_valid && cmd_ready) cyc = 0;
    else cyc++;
    if (rd_en) begin
      if (rdq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_unexpected: got read %0d/%0d, expected none", rd_addr1, rd_addr2);
      end else begin
        me = rdq.pop_front();
        chk("rd_cyc", cyc, me.cyc);
        chk("rd_addr1", int'(rd_addr1), me.a1);
        chk("rd_addr2", int'(rd_addr2), me.a2);
      end
    end
    if (wr_en && wr_ready) begin
      if (wrq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr_unexpected: got write %0d, expected none", wr_addr);
      end else begin
        me = wrq.pop_front();
        chk("wr_cyc", cyc, me.cyc);
        chk("wr_addr", int'(wr_addr), me.a1);
        chk("unit_op", int'(unit_op), me.op);
      end
    end
    if (done) begin
      if (dnq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL done_unexpected: got done, expected none");
      end else begin
        me = dnq.pop_front();
        chk("done_cyc", cyc, me.cyc);
        chk("err", int'(err), me.e);
      end
    end
  end

  task automatic send(input int op, input int s1, input int s2, input int d, input int len);
    bit got;
    got = 0;
    cmd_op = VecUnitOp_t'(op);
    cmd_src1 = 8'(s1);
    cmd_src2 = 8'(s2);
    cmd_dst = 8'(d);
    cmd_len = 8'(len);
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      got = cmd_ready;
    end
    chk("accept", int'(got), 1);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle;
    bit idle;
    idle = 0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clock);
      idle = rdq.size() == 0 && wrq.size() == 0 && dnq.size() == 0 && !busy;
    end
    chk("drained", rdq.size() + wrq.size() + dnq.size() + int'(busy), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int acc;
    #1;
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_unit_op", int'(unit_op), int'(VEC_UNIT_OP_ADD));
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rel_cmd_ready", int'(cmd_ready), 1);
    chk("rel_wr_en", int'(wr_en), 0);
    @(posedge clock);
    #1;
    // basic len=3 SUB
    prd(1, 4, 8); prd(2, 5, 9); prd(3, 6, 10);
    pwr(2, 12, 1); pwr(3, 13, 1); pwr(4, 14, 1);
    pdn(5, 0);
    send(1, 4, 8, 12, 3);
    wait_idle();
    // write stall on cycles 2-3
    prd(1, 20, 30); prd(4, 21, 31);
    pwr(4, 40, 2); pwr(5, 41, 2);
    pdn(6, 0);
    send(2, 20, 30, 40, 2);
    @(posedge clock);
    #1 wr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("stall_wr_en", int'(wr_en), 1);
      chk("stall_wr_addr", int'(wr_addr), 40);
      chk("stall_rd_en", int'(rd_en), 0);
      @(posedge clock);
      #1;
    end
    wr_ready = 1'b1;
    wait_idle();
    // zero-length command
    pdn(1, 0);
    send(0, 7, 7, 7, 0);
    @(negedge clock);
    @(negedge clock);
    chk("len0_ready_c2", int'(cmd_ready), 1);
    wait_idle();
    // destination wrapping past the top of the address space
`ifdef VEC_CTRL_RANGE_CHECK_EN
    pdn(1, 1);
`else
    prd(1, 0, 100); prd(2, 1, 101); prd(3, 2, 102); prd(4, 3, 103);
    pwr(2, 254, 0); pwr(3, 255, 0); pwr(4, 0, 0); pwr(5, 1, 0);
    pdn(6, 0);
`endif
    send(0, 0, 100, 254, 4);
    wait_idle();
    // reset in the middle of a len=8 command
    prd(1, 50, 60); prd(2, 51, 61);
    pwr(2, 70, 2);
    send(2, 50, 60, 70, 8);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_cmd_ready", int'(cmd_ready), 0);
    chk("mid_rd_en", int'(rd_en), 0);
    chk("mid_wr_en", int'(wr_en), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_err", int'(err), 0);
    chk("mid_rd_addr1", int'(rd_addr1), 0);
    chk("mid_rd_addr2", int'(rd_addr2), 0);
    chk("mid_wr_addr", int'(wr_addr), 0);
    chk("mid_unit_op", int'(unit_op), int'(VEC_UNIT_OP_ADD));
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", int'(cmd_ready), 1);
    chk("post_rst_busy", int'(busy), 0);
    wait_idle();
    prd(1, 1, 2);
    pwr(2, 3, 1);
    pdn(3, 0);
    send(1, 1, 2, 3, 1);
    wait_idle();
    // back-to-back commands with cmd_valid held through busy
    prd(1, 10, 11); prd(2, 11, 12);
    pwr(2, 12, 1); pwr(3, 13, 1);
    pdn(4, 0);
    prd(1, 100, 110);
    pwr(2, 120, 0);
    pdn(3, 0);
    cmd_op = VEC_UNIT_OP_SUB;
    cmd_src1 = 8'd10;
    cmd_src2 = 8'd11;
    cmd_dst = 8'd12;
    cmd_len = 8'd2;
    cmd_valid = 1'b1;
    @(negedge clock);
    chk("a_accept", int'(cmd_ready), 1);
    @(posedge clock);
    #1;
    cmd_op = VEC_UNIT_OP_ADD;
    cmd_src1 = 8'd100;
    cmd_src2 = 8'd110;
    cmd_dst = 8'd120;
    cmd_len = 8'd1;
    acc = 0;
    for (int k = 1; k < 50 && acc == 0; k++) begin
      @(negedge clock);
      if (cmd_ready) acc = k;
    end
    chk("b_accept_cyc", acc, 5);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
